regfile_wb_arbiter: RTL and testbench

//  Shares the register bank's single write port among N_REQ writeback sources (ALU, load unit, mul/div)

---
 rtl/rv_core_pkg.sv | 21 ++
 rtl/regfile_wb_arbiter_if.sv | 28 ++
 rtl/rr_arbiter.sv | 46 ++++
 rtl/regfile_wb_arbiter.sv | 86 ++++++++
 tb/tb_regfile_wb_arbiter.sv | 239 +++++++++++++++++++++++
 5 files changed

// File: rtl/rv_core_pkg.sv
// Core-wide constants shared by the register bank and its writeback arbiter.
package rv_core_pkg;

    localparam int unsigned XLEN       = 32;
    localparam int unsigned REG_ADDR_W = 5;
    localparam int unsigned NUM_REGS   = 32;

    typedef logic [REG_ADDR_W-1:0] reg_addr_t;
    typedef logic [NUM_REGS-1:0]   reg_mask_t;

    localparam reg_addr_t REG_ZERO = 5'd0;

    // One-hot mask of a register index, with x0 never represented.
    function automatic reg_mask_t reg_bit(input reg_addr_t r);
        reg_mask_t m;
        m    = '0;
        m[r] = (r != REG_ZERO);
        return m;
    endfunction

endpackage

// File: rtl/regfile_wb_arbiter_if.sv
// Writeback request bundle: N_REQ sources presenting rd/data with a one-hot grant back.
interface regfile_wb_arbiter_if
    import rv_core_pkg::*;
#(
    parameter int unsigned N_REQ = 3,
    parameter int unsigned XLEN  = rv_core_pkg::XLEN
);

    logic [N_REQ-1:0]            wb_valid;
    logic [REG_ADDR_W*N_REQ-1:0] wb_rd;
    logic [XLEN*N_REQ-1:0]       wb_data;
    logic [N_REQ-1:0]            wb_ready;

    modport master (
        output wb_valid,
        output wb_rd,
        output wb_data,
        input  wb_ready
    );

    modport slave (
        input  wb_valid,
        input  wb_rd,
        input  wb_data,
        output wb_ready
    );

endinterface

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: combinational one-hot grant searched from a rotating pointer.
module rr_arbiter #(
    parameter int unsigned N_REQ = 3
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [N_REQ-1:0]         req,
    input  logic                     advance,
    output logic [N_REQ-1:0]         grant,
    output logic [$clog2(N_REQ)-1:0] grant_idx
);

    localparam int unsigned IDX_W = $clog2(N_REQ);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_REQ - 1);

    logic [IDX_W-1:0] ptr;
    logic             found;
    int unsigned      cand;

    always_comb begin
        grant     = '0;
        grant_idx = '0;
        found     = 1'b0;
        cand      = 0;
        for (int unsigned off = 0; off < N_REQ; off++) begin
            cand = int'(ptr) + off;
            if (cand >= N_REQ) begin
                cand = cand - N_REQ;
            end
            if (!found && req[cand]) begin
                found       = 1'b1;
                grant[cand] = 1'b1;
                grant_idx   = IDX_W'(cand);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr <= '0;
        end else if (advance) begin
            ptr <= (grant_idx == LAST_IDX) ? '0 : grant_idx + 1'b1;
        end
    end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Shares the register bank write port among writeback sources and tracks pending destinations.
module regfile_wb_arbiter
    import rv_core_pkg::*;
#(
    parameter int unsigned N_REQ = 3,
    parameter int unsigned XLEN  = rv_core_pkg::XLEN
) (
    input  logic                 clk,
    input  logic                 rst,
    regfile_wb_arbiter_if.slave  wb,
    input  logic                 issue_valid,
    input  logic [4:0]           issue_rd,
    output logic                 issue_ready,
    input  logic [4:0]           rs1,
    input  logic [4:0]           rs2,
    output logic                 rs1_busy,
    output logic                 rs2_busy,
    output logic                 rf_we,
    output logic [4:0]           rf_rd,
    output logic [XLEN-1:0]      rf_wd,
    output logic                 wb_err
);

    localparam int unsigned IDX_W = $clog2(N_REQ);

    logic [IDX_W-1:0] grant_idx;
    logic             hs;
    reg_addr_t        sel_rd;
    logic [XLEN-1:0]  sel_data;
    reg_mask_t        pending;
    reg_mask_t        pending_next;
    logic             issue_fire;

    rr_arbiter #(
        .N_REQ(N_REQ)
    ) u_arb (
        .clk      (clk),
        .rst      (rst),
        .req      (wb.wb_valid),
        .advance  (hs),
        .grant    (wb.wb_ready),
        .grant_idx(grant_idx)
    );

    assign hs       = |(wb.wb_valid & wb.wb_ready);
    assign sel_rd   = wb.wb_rd[int'(grant_idx)*REG_ADDR_W +: REG_ADDR_W];
    assign sel_data = wb.wb_data[int'(grant_idx)*XLEN +: XLEN];

    assign issue_ready = (issue_rd == REG_ZERO) | ~pending[issue_rd];
    assign issue_fire  = issue_valid & issue_ready;
    assign rs1_busy    = (rs1 != REG_ZERO) & pending[rs1];
    assign rs2_busy    = (rs2 != REG_ZERO) & pending[rs2];

    // Clear uses the registered write port, so it lands on the edge the bank commits.
    always_comb begin
        pending_next = pending;
        if (rf_we) begin
            pending_next = pending_next & ~reg_bit(rf_rd);
        end
        if (issue_fire) begin
            pending_next = pending_next | reg_bit(issue_rd);
        end
        pending_next[0] = 1'b0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pending <= '0;
            rf_we   <= 1'b0;
            rf_rd   <= '0;
            rf_wd   <= '0;
            wb_err  <= 1'b0;
        end else begin
            pending <= pending_next;
            rf_we   <= hs && (sel_rd != REG_ZERO);
            if (hs && (sel_rd != REG_ZERO)) begin
                rf_rd <= sel_rd;
                rf_wd <= sel_data;
                if (!pending[sel_rd]) begin
                    wb_err <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed bench with a spec-level model of grant order, write port and scoreboard.
module tb_regfile_wb_arbiter;
    import rv_core_pkg::*;

    localparam int N = 3;

    logic        clk = 1'b0;
    logic        rst;
    logic        issue_valid;
    logic [4:0]  issue_rd;
    logic        issue_ready;
    logic [4:0]  rs1, rs2;
    logic        rs1_busy, rs2_busy;
    logic        rf_we;
    logic [4:0]  rf_rd;
    logic [31:0] rf_wd;
    logic        wb_err;

    int checks   = 0;
    int failures = 0;
    bit started  = 1'b0;

    regfile_wb_arbiter_if #(.N_REQ(N), .XLEN(32)) wb ();

    regfile_wb_arbiter #(.N_REQ(N), .XLEN(32)) dut (
        .clk        (clk),
        .rst        (rst),
        .wb         (wb),
        .issue_valid(issue_valid),
        .issue_rd   (issue_rd),
        .issue_ready(issue_ready),
        .rs1        (rs1),
        .rs2        (rs2),
        .rs1_busy   (rs1_busy),
        .rs2_busy   (rs2_busy),
        .rf_we      (rf_we),
        .rf_rd      (rf_rd),
        .rf_wd      (rf_wd),
        .wb_err     (wb_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h t=%0t", name, act, exp, $time);
        end
    endtask

    // Model: pending set as a bit vector, pointer as an integer, write port as last accepted result.
    logic [31:0] m_pend = '0;
    int          m_ptr  = 0;
    logic        m_we   = 1'b0;
    logic [4:0]  m_rd   = '0;
    logic [31:0] m_wd   = '0;
    logic        m_err  = 1'b0;

    function automatic int winner();
        for (int k = 0; k < N; k++) begin
            int c;
            c = (m_ptr + k) % N;
            if (wb.wb_valid[c]) return c;
        end
        return -1;
    endfunction

    always @(posedge clk or posedge rst) begin : model
        int          w;
        logic [31:0] old;
        logic [4:0]  r;
        if (rst) begin
            m_pend = '0; m_ptr = 0; m_we = 1'b0; m_rd = '0; m_wd = '0; m_err = 1'b0;
        end else begin
            w   = winner();
            old = m_pend;
            if (m_we) m_pend[m_rd] = 1'b0;
            if (issue_valid && issue_rd != 0 && !old[issue_rd]) m_pend[issue_rd] = 1'b1;
            m_we = 1'b0;
            if (w >= 0) begin
                r = wb.wb_rd[5*w +: 5];
                if (r != 0) begin
                    if (!old[r]) m_err = 1'b1;
                    m_we = 1'b1;
                    m_rd = r;
                    m_wd = wb.wb_data[32*w +: 32];
                end
                m_ptr = (w == N-1) ? 0 : w + 1;
            end
        end
    end

    always @(negedge clk) begin : compare
        int w;
        if (started) begin
            w = winner();
            check("wb_ready", {29'd0, wb.wb_ready}, (w < 0) ? 32'd0 : (32'd1 << w));
            check("issue_ready", {31'd0, issue_ready}, {31'd0, (issue_rd == 0) || !m_pend[issue_rd]});
            check("rs1_busy", {31'd0, rs1_busy}, {31'd0, (rs1 != 0) && m_pend[rs1]});
            check("rs2_busy", {31'd0, rs2_busy}, {31'd0, (rs2 != 0) && m_pend[rs2]});
            check("rf_we", {31'd0, rf_we}, {31'd0, m_we});
            if (m_we) begin
                check("rf_rd", {27'd0, rf_rd}, {27'd0, m_rd});
                check("rf_wd", rf_wd, m_wd);
            end
            check("wb_err", {31'd0, wb_err}, {31'd0, m_err});
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; issue_valid = 1'b0; issue_rd = '0; rs1 = '0; rs2 = '0;
        wb.wb_valid = '0; wb.wb_rd = '0; wb.wb_data = '0;
        tick(); tick();
        started = 1'b1;
        check("rst_rf_we", {31'd0, rf_we}, 0);
        check("rst_wb_err", {31'd0, wb_err}, 0);
        rst = 1'b0;

        // Issue x5, then requester 1 writes it back.
        issue_valid = 1'b1; issue_rd = 5'd5; #3;
        check("t2_issue_ready", {31'd0, issue_ready}, 1);
        tick();
        issue_valid = 1'b0; rs1 = 5'd5;
        wb.wb_valid = 3'b010; wb.wb_rd = 15'd5 << 5; wb.wb_data = {32'd0, 32'hDEADBEEF, 32'd0}; #3;
        check("t2_busy_before", {31'd0, rs1_busy}, 1);
        check("t2_grant", {29'd0, wb.wb_ready}, 3'b010);
        tick();
        wb.wb_valid = '0; #3;
        check("t2_we", {31'd0, rf_we}, 1);
        check("t2_rd", {27'd0, rf_rd}, 5);
        check("t2_wd", rf_wd, 32'hDEADBEEF);
        check("t2_busy_during", {31'd0, rs1_busy}, 1);
        tick(); #3;
        check("t2_we_off", {31'd0, rf_we}, 0);
        check("t2_busy_after", {31'd0, rs1_busy}, 0);
        check("t2_wd_hold", rf_wd, 32'hDEADBEEF);

        // Requester 2 writes back x0: consumed, no write, no error; pointer wraps to 0.
        wb.wb_valid = 3'b100; wb.wb_rd = '0; wb.wb_data = {32'h1234, 64'd0}; #3;
        check("t5_grant", {29'd0, wb.wb_ready}, 3'b100);
        tick();
        wb.wb_valid = '0; #3;
        check("t5_we", {31'd0, rf_we}, 0);
        check("t5_err", {31'd0, wb_err}, 0);

        // All three requesters valid back to back.
        for (int r = 1; r <= 4; r++) begin
            issue_valid = 1'b1; issue_rd = 5'(r); tick();
        end
        issue_valid = 1'b0;
        wb.wb_valid = 3'b111; wb.wb_rd = {5'd3, 5'd2, 5'd1};
        wb.wb_data = {32'h333, 32'h222, 32'h111}; #3;
        check("t3_grant0", {29'd0, wb.wb_ready}, 3'b001);
        tick();
        wb.wb_rd[4:0] = 5'd4; wb.wb_data[31:0] = 32'h444; #3;
        check("t3_grant1", {29'd0, wb.wb_ready}, 3'b010);
        check("t3_rd1", {27'd0, rf_rd}, 1);
        tick(); #3;
        check("t3_grant2", {29'd0, wb.wb_ready}, 3'b100);
        check("t3_rd2", {27'd0, rf_rd}, 2);
        check("t3_we2", {31'd0, rf_we}, 1);
        tick(); #3;
        check("t3_grant3", {29'd0, wb.wb_ready}, 3'b001);
        check("t3_rd3", {27'd0, rf_rd}, 3);
        tick();
        wb.wb_valid = '0; #3;
        check("t3_rd4", {27'd0, rf_rd}, 4);
        check("t3_wd4", rf_wd, 32'h444);
        tick(); #3;
        check("t3_err", {31'd0, wb_err}, 0);

        // Issue blocked on pending x7; x0 always issues.
        issue_valid = 1'b1; issue_rd = 5'd7; tick(); #3;
        check("t4_blocked", {31'd0, issue_ready}, 0);
        tick();
        issue_rd = 5'd0; #3;
        check("t4_x0_ok", {31'd0, issue_ready}, 1);
        tick();
        issue_valid = 1'b0; rs2 = 5'd7;
        wb.wb_valid = 3'b010; wb.wb_rd = 15'd7 << 5; wb.wb_data = {32'd0, 32'h77, 32'd0}; #3;
        check("t4_busy7", {31'd0, rs2_busy}, 1);
        tick();
        wb.wb_valid = '0;
        tick(); #3;
        check("t4_free7", {31'd0, rs2_busy}, 0);

        // Writeback to a non-pending register raises the sticky error.
        wb.wb_valid = 3'b001; wb.wb_rd = 15'd9; wb.wb_data = {64'd0, 32'h99}; #3;
        check("t6_grant", {29'd0, wb.wb_ready}, 3'b001);
        check("t6_err_before", {31'd0, wb_err}, 0);
        tick();
        wb.wb_valid = '0; #3;
        check("t6_err", {31'd0, wb_err}, 1);
        check("t6_we", {31'd0, rf_we}, 1);
        check("t6_rd", {27'd0, rf_rd}, 9);
        tick(); tick(); #3;
        check("t6_err_sticky", {31'd0, wb_err}, 1);

        // Fill pending x1..x15 with a write in flight, then reset asynchronously.
        for (int r = 1; r <= 15; r++) begin
            issue_valid = 1'b1; issue_rd = 5'(r);
            if (r == 15) begin
                wb.wb_valid = 3'b001; wb.wb_rd = 15'd16; wb.wb_data = {64'd0, 32'hABC};
            end
            tick();
        end
        issue_valid = 1'b0; wb.wb_valid = '0; rs1 = 5'd15; rs2 = 5'd1; #3;
        check("t1_busy15", {31'd0, rs1_busy}, 1);
        check("t1_we_pre", {31'd0, rf_we}, 1);
        rst = 1'b1; #1;
        check("t1_we", {31'd0, rf_we}, 0);
        check("t1_rd", {27'd0, rf_rd}, 0);
        check("t1_wd", rf_wd, 0);
        check("t1_err", {31'd0, wb_err}, 0);
        for (int r = 0; r < 32; r++) begin
            rs1 = 5'(r); #1;
            check("t1_pending_clear", {31'd0, rs1_busy}, 0);
        end
        tick();
        rst = 1'b0;
        tick(); tick();
        started = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
